// File: rtl/plic_pkg.sv
// Shared constants for the single-target PLIC core: register map, source limit and ID width.
package plic_pkg;

   localparam int MAX_SRC = 15;
   localparam int ID_W    = 4;

   localparam logic [7:0] PRIO_BASE    = 8'h00;
   localparam logic [7:0] ENABLE_ADDR  = 8'h40;
   localparam logic [7:0] THRESH_ADDR  = 8'h44;
   localparam logic [7:0] CLAIM_ADDR   = 8'h48;
   localparam logic [7:0] PENDING_ADDR = 8'h4C;

endpackage

// File: rtl/plic_prio_max.sv
// Combinational arbiter: highest-priority eligible source, lowest ID wins a tie, 0 when none.
module plic_prio_max
   import plic_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3
) (
   input  logic [NUM_SRC-1:0]        eligible,
   input  logic [NUM_SRC*PRIO_W-1:0] prio_flat,
   output logic [ID_W-1:0]           best_id,
   output logic [PRIO_W-1:0]         best_prio
);

   // Strict '>' while scanning upward keeps the lowest ID on equal priority.
   always_comb begin
      best_id   = '0;
      best_prio = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (eligible[k-1] && (prio_flat[(k-1)*PRIO_W +: PRIO_W] > best_prio)) begin
            best_id   = ID_W'(k);
            best_prio = prio_flat[(k-1)*PRIO_W +: PRIO_W];
         end
      end
   end

endmodule

// File: rtl/plic_target_ctrl.sv
// Single-target PLIC core: configuration registers, arbitration, irq line and claim/complete handshake.
module plic_target_ctrl
   import plic_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] req_i,
   output logic [NUM_SRC-1:0] complete_o,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [7:0]         addr_i,
   input  logic [31:0]        wdata_i,
   output logic [31:0]        rdata_o,
   output logic               irq_o
);

   // Per-source vectors use bit k-1 for source k throughout.
   logic [PRIO_W-1:0]         prio_q [NUM_SRC];
   logic [NUM_SRC-1:0]        enable_q;
   logic [NUM_SRC-1:0]        in_service_q;
   logic [PRIO_W-1:0]         threshold_q;

   logic [NUM_SRC*PRIO_W-1:0] prio_flat;
   logic [NUM_SRC-1:0]        prio_nz;
   logic [NUM_SRC-1:0]        eligible;
   logic [ID_W-1:0]           best_id;
   logic [PRIO_W-1:0]         best_prio;
   logic [ID_W-1:0]           claim_id;

   logic                      wr;
   logic                      rd;
   logic [5:0]                word;
   logic [NUM_SRC-1:0]        claim_set;
   logic [NUM_SRC-1:0]        done_set;
   logic [31:0]               rd_val;
   logic                      unused_addr_bits;

   assign unused_addr_bits = ^addr_i[1:0];
   assign wr   = we_i;
   assign rd   = re_i & ~we_i;
   assign word = addr_i[7:2];

   always_comb begin
      prio_flat = '0;
      prio_nz   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         prio_flat[k*PRIO_W +: PRIO_W] = prio_q[k];
         prio_nz[k]                    = |prio_q[k];
      end
   end

   assign eligible = req_i & ~in_service_q & enable_q & prio_nz;

   plic_prio_max #(
      .NUM_SRC (NUM_SRC),
      .PRIO_W  (PRIO_W)
   ) u_prio_max (
      .eligible  (eligible),
      .prio_flat (prio_flat),
      .best_id   (best_id),
      .best_prio (best_prio)
   );

   assign claim_id = ((best_id != '0) && (best_prio > threshold_q)) ? best_id : '0;

   // A complete is accepted only for an in-service source whose pulse is not already running.
   always_comb begin
      claim_set = '0;
      done_set  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (rd && (word == CLAIM_ADDR[7:2]) && (claim_id == ID_W'(k + 1)))
            claim_set[k] = 1'b1;
         if (wr && (word == CLAIM_ADDR[7:2]) && (wdata_i == 32'(k + 1)) &&
             in_service_q[k] && !complete_o[k])
            done_set[k] = 1'b1;
      end
   end

   always_comb begin
      rd_val = '0;
      case (word)
         ENABLE_ADDR[7:2]:  rd_val[NUM_SRC:1] = enable_q;
         THRESH_ADDR[7:2]:  rd_val = 32'(threshold_q);
         CLAIM_ADDR[7:2]:   rd_val = 32'(claim_id);
         PENDING_ADDR[7:2]: rd_val[NUM_SRC:1] = eligible;
         default: begin
            for (int k = 0; k < NUM_SRC; k++) begin
               if (word == PRIO_BASE[7:2] + 6'(k + 1))
                  rd_val = 32'(prio_q[k]);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_SRC; k++)
            prio_q[k] <= '0;
         enable_q     <= '0;
         threshold_q  <= '0;
         in_service_q <= '0;
         complete_o   <= '0;
         rdata_o      <= '0;
         irq_o        <= 1'b0;
      end else begin
         if (wr) begin
            case (word)
               ENABLE_ADDR[7:2]: enable_q    <= wdata_i[NUM_SRC:1];
               THRESH_ADDR[7:2]: threshold_q <= wdata_i[PRIO_W-1:0];
               default: begin
                  for (int k = 0; k < NUM_SRC; k++) begin
                     if (word == PRIO_BASE[7:2] + 6'(k + 1))
                        prio_q[k] <= wdata_i[PRIO_W-1:0];
                  end
               end
            endcase
         end
         if (rd)
            rdata_o <= rd_val;
         complete_o <= done_set;
         // Clearing on the pulse cycle means in_service drops one cycle after the gateway saw complete.
         in_service_q <= (in_service_q | claim_set) & ~complete_o;
         irq_o        <= (claim_id != '0);
      end
   end

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Directed plus randomized bench for plic_target_ctrl against a rule-level reference model.
module tb_plic_target_ctrl;

   localparam int N  = 8;
   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_i = '0;
   logic [N-1:0]  complete_o;
   logic          we_i = 1'b0;
   logic          re_i = 1'b0;
   logic [7:0]    addr_i = '0;
   logic [31:0]   wdata_i = '0;
   logic [31:0]   rdata_o;
   logic          irq_o;

   int checks = 0;
   int errors = 0;

   int m_prio [1:N];
   bit m_en   [1:N];
   bit m_ins  [1:N];
   int m_thr;

   plic_target_ctrl #(.NUM_SRC(N), .PRIO_W(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .complete_o (complete_o),
      .we_i       (we_i),
      .re_i       (re_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .irq_o      (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int k = 1; k <= N; k++) begin
         m_prio[k] = 0;
         m_en[k]   = 1'b0;
         m_ins[k]  = 1'b0;
      end
      m_thr = 0;
   endtask

   function automatic bit m_elig(input int k);
      return (req_i[k-1] === 1'b1) && !m_ins[k] && m_en[k] && (m_prio[k] != 0);
   endfunction

   // Highest priority first, then the lowest ID holding it.
   function automatic int m_best();
      int mx = 0;
      for (int k = 1; k <= N; k++)
         if (m_elig(k) && m_prio[k] > mx) mx = m_prio[k];
      if (mx == 0) return 0;
      for (int k = 1; k <= N; k++)
         if (m_elig(k) && m_prio[k] == mx) return k;
      return 0;
   endfunction

   function automatic int m_claim();
      int b = m_best();
      return (b != 0 && m_prio[b] > m_thr) ? b : 0;
   endfunction

   function automatic logic [31:0] m_reg(input logic [7:0] a);
      logic [31:0] v = '0;
      int w = int'(a[7:2]);
      if (w >= 1 && w <= N) v = 32'(m_prio[w]);
      else if (a[7:2] == 6'h10) begin
         for (int k = 1; k <= N; k++) v[k] = m_en[k];
      end
      else if (a[7:2] == 6'h11) v = 32'(m_thr);
      else if (a[7:2] == 6'h12) v = 32'(m_claim());
      else if (a[7:2] == 6'h13) begin
         for (int k = 1; k <= N; k++) v[k] = m_elig(k);
      end
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      int w = int'(a[7:2]);
      we_i = 1'b1; addr_i = a; wdata_i = d;
      cyc();
      we_i = 1'b0;
      if (w >= 1 && w <= N) m_prio[w] = int'(d & 32'h7);
      else if (a[7:2] == 6'h10) begin
         for (int k = 1; k <= N; k++) m_en[k] = d[k];
      end
      else if (a[7:2] == 6'h11) m_thr = int'(d & 32'h7);
   endtask

   task automatic claim(input string tag);
      int exp = m_claim();
      re_i = 1'b1; addr_i = 8'h48;
      cyc();
      re_i = 1'b0;
      chk(tag, rdata_o, 32'(exp));
      if (exp != 0) m_ins[exp] = 1'b1;
   endtask

   task automatic check_reg(input string tag, input logic [7:0] a);
      logic [31:0] exp;
      if (a[7:2] == 6'h12) claim(tag);
      else begin
         exp = m_reg(a);
         re_i = 1'b1; addr_i = a;
         cyc();
         re_i = 1'b0;
         chk(tag, rdata_o, exp);
      end
   endtask

   task automatic complete(input string tag, input int w);
      bit ok = (w >= 1 && w <= N) && m_ins[w];
      logic [31:0] exp = ok ? (32'd1 << (w - 1)) : 32'd0;
      bus_wr(8'h48, 32'(w));
      chk({tag, "_pulse"}, 32'(complete_o), exp);
      if (ok) req_i[w-1] = 1'b0;
      cyc();
      chk({tag, "_pulse_end"}, 32'(complete_o), 32'd0);
      if (ok) m_ins[w] = 1'b0;
   endtask

   task automatic check_irq(input string tag);
      cyc();
      chk(tag, 32'(irq_o), 32'(m_claim() != 0));
   endtask

   initial begin
      logic [31:0] r;
      m_reset();
      repeat (3) cyc();
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_complete", 32'(complete_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      rst_n = 1'b1;
      cyc();

      for (int a = 0; a < 256; a += 4)
         check_reg($sformatf("rst_reg_%0h", a), 8'(a));

      // Single source
      bus_wr(8'h0C, 32'd2);
      bus_wr(8'h40, 32'h08);
      bus_wr(8'h44, 32'd0);
      check_irq("ss_irq_idle");
      req_i[2] = 1'b1;
      check_irq("ss_irq_up");
      check_irq("ss_irq_hold");
      check_reg("ss_pending", 8'h4C);
      claim("ss_claim");
      check_irq("ss_irq_drop");
      check_reg("ss_pending_claimed", 8'h4C);
      complete("ss_complete", 3);
      check_reg("ss_pending_after", 8'h4C);
      check_irq("ss_irq_after");

      // Priority and ties
      bus_wr(8'h08, 32'd4);
      bus_wr(8'h14, 32'd6);
      bus_wr(8'h1C, 32'd6);
      bus_wr(8'h40, 32'h0000_00A4);
      req_i = 8'b0101_0010;
      check_irq("pt_irq");
      claim("pt_claim_a");
      claim("pt_claim_b");
      claim("pt_claim_c");
      claim("pt_claim_d");
      complete("pt_comp_7", 7);
      complete("pt_comp_2", 2);
      complete("pt_comp_5", 5);
      req_i = 8'b0101_0010;
      bus_wr(8'h44, 32'd6);
      check_irq("pt_thr_irq");
      claim("pt_thr_claim");

      // Threshold and enable gating
      req_i = '0;
      bus_wr(8'h04, 32'd1);
      bus_wr(8'h40, 32'h02);
      bus_wr(8'h44, 32'd1);
      req_i[0] = 1'b1;
      check_irq("te_thr1");
      bus_wr(8'h44, 32'd0);
      check_irq("te_thr0");
      bus_wr(8'h40, 32'h00);
      check_irq("te_dis");
      check_reg("te_pending", 8'h4C);

      // Bad completes
      bus_wr(8'h40, 32'h02);
      claim("bc_claim");
      complete("bc_zero", 0);
      complete("bc_nine", 9);
      complete("bc_idle", 5);
      check_reg("bc_pending", 8'h4C);
      claim("bc_reclaim");
      complete("bc_good", 1);

      // Reset mid-flight
      bus_wr(8'h08, 32'd3);
      bus_wr(8'h0C, 32'd2);
      bus_wr(8'h40, 32'h0C);
      req_i = 8'b0000_0110;
      claim("rm_claim_a");
      claim("rm_claim_b");
      we_i = 1'b1; addr_i = 8'h48; wdata_i = 32'd2;
      cyc();
      we_i = 1'b0;
      chk("rm_pulse", 32'(complete_o), 32'h02);
      #1 rst_n = 1'b0;
      #1;
      chk("rm_rst_complete", 32'(complete_o), 32'd0);
      chk("rm_rst_irq", 32'(irq_o), 32'd0);
      chk("rm_rst_rdata", rdata_o, 32'd0);
      req_i = '0;
      m_reset();
      @(negedge clk) rst_n = 1'b1;
      cyc();
      for (int a = 4; a <= 8'h44; a += 4)
         check_reg($sformatf("rm_cfg_%0h", a), 8'(a));

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 7))
            0: req_i = N'($urandom);
            1: bus_wr(8'($urandom_range(0, N + 3) * 4), $urandom);
            2: bus_wr(8'h40, $urandom);
            3: bus_wr(8'h44, 32'($urandom_range(0, 7)));
            4: claim($sformatf("rnd_claim_%0d", i));
            5: complete($sformatf("rnd_comp_%0d", i), $urandom_range(0, 10));
            6: check_reg($sformatf("rnd_reg_%0d", i), 8'($urandom_range(0, 19) * 4));
            default: bus_wr(8'(8'h50 + $urandom_range(0, 43) * 4), $urandom);
         endcase
         check_irq($sformatf("rnd_irq_%0d", i));
      end

      r = 32'(errors);
      $display("CHECKS %0d ERRORS %0d", checks, r);
      $finish;
   end

endmodule
